ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared `ps2_clk`/`ps2_data` lines. It is the transmit side of the PS/2 link whose receive side is the existing keyboard decoder. It runs in the 100 MHz `pclk100` domain and drives the lines open-drain through output-enable signals; the top level builds the tri-states. While `busy` is high, the receiver ignores line activity.

---
 rtl/ps2_host_tx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte host-to-device over open-drain PS/2 clock/data lines.
// Define PS2_TX_FILTER_EN to add an 8-sample glitch filter on the synchronized ps2_clk.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int START_CYCLES   = 200,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int MAX_A      = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int MAX_CYCLES = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW         = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);

    localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [9:0]      sh_q, sh_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            tx_done_q, tx_done_d;
    logic            tx_error_q, tx_error_d;
    logic            clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic            clk_prev_q;
    logic            clk_line;
    logic            fe;
    logic            ack_fail;

`ifdef PS2_TX_FILTER_EN
    // The filtered clock only follows the synchronizer after 8 consecutive differing samples.
    logic [2:0] filt_cnt_q, filt_cnt_d;
    logic       clk_filt_q, clk_filt_d;

    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != clk_filt_q) begin
            if (filt_cnt_q == 3'd7) begin
                clk_filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_cnt_q <= '0;
            clk_filt_q <= 1'b1;
        end else begin
            filt_cnt_q <= filt_cnt_d;
            clk_filt_q <= clk_filt_d;
        end
    end

    assign clk_line = clk_filt_q;
`else
    assign clk_line = clk_s2_q;
`endif

    assign fe          = clk_prev_q & ~clk_line;
    assign tx_ready    = (state_q == IDLE) && !tx_done_q && !tx_error_q;
    assign busy        = (state_q != IDLE);
    assign tx_done     = tx_done_q;
    assign tx_error    = tx_error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        sh_d       = sh_q;
        bitcnt_d   = bitcnt_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        tx_done_d  = 1'b0;
        tx_error_d = 1'b0;
        ack_fail   = 1'b0;

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid && tx_ready) begin
                    state_d  = INHIBIT;
                    cnt_d    = '0;
                    sh_d     = {1'b1, ~^tx_data, tx_data};
                    clk_oe_d = 1'b1;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d   = START;
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                end
            end
            START: begin
                if (cnt_q == START_LAST) begin
                    state_d  = BITS;
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                    bitcnt_d = '0;
                end
            end
            BITS: begin
                // Device samples on its rising edge, so each bit is set up right after a falling edge.
                if (fe) begin
                    data_oe_d = ~sh_q[0];
                    sh_d      = {1'b0, sh_q[9:1]};
                    bitcnt_d  = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (fe) begin
                    if (!data_s2_q) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        ack_fail = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_line && data_s2_q) begin
                    state_d   = IDLE;
                    tx_done_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase

        // Timeout or NACK abandons the transfer and frees both lines at once.
        if ((state_q == BITS || state_q == ACK || state_q == WAIT_IDLE) &&
            (cnt_q >= TO_LAST || ack_fail)) begin
            state_d    = IDLE;
            tx_error_d = 1'b1;
            tx_done_d  = 1'b0;
            clk_oe_d   = 1'b0;
            data_oe_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            bitcnt_q   <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            bitcnt_q   <= bitcnt_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            tx_done_q  <= tx_done_d;
            tx_error_q <= tx_error_d;
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            data_s1_q  <= ps2_data_in;
            data_s2_q  <= data_s1_q;
            clk_prev_q <= clk_line;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a PS/2 device model with shortened timing parameters.
// Expected pulses and device-captured frames are checked by a scoreboard monitor.
module tb_ps2_host_tx;
    localparam int INHIBIT = 120;
    localparam int START   = 20;
    localparam int TIMEOUT = 3000;
    localparam int HALF    = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clk_in  = !(ps2_clk_oe || dev_clk_low);
    assign ps2_data_in = !(ps2_data_oe || dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .START_CYCLES  (START),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .busy       (busy),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_done;
        logic        check_frame;
        logic [10:0] frame;
    } exp_t;

    typedef enum {DEV_NORMAL, DEV_SILENT, DEV_NACK} dev_mode_t;

    exp_t        exp_q[$];
    logic [10:0] dev_frames[$];
    dev_mode_t   dev_mode = DEV_NORMAL;
    logic        dev_active = 1'b0;
    logic        glitch_en = 1'b0;
    int          dev_edges = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accept_count = 0;
    int          inhibit_len = 0;
    int          start_len = 0;
    int          release_cyc = 0;
    int          timeout_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name, input string detail);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic parity, input logic expect_done);
        exp_t e;
        int   n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            failNow("tx_ready_wait", "tx_ready still 0 after 1000 cycles, required 1");
            return;
        end
        e.is_done     = expect_done;
        e.check_frame = expect_done;
        e.frame       = {1'b1, parity, data, 1'b0};
        exp_q.push_back(e);
        tx_data  = data;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~data;
        checkOutput("clk_oe_after_accept", 32'(ps2_clk_oe), 32'd1);
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || dev_active) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) failNow(name, "no response within 5000 cycles, required completion");
    endtask

    task automatic waitPulse(output logic seen);
        int n = 0;
        seen = 1'b0;
        while (n < 10000) begin
            @(negedge clk);
            n++;
            if (tx_done || tx_error) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) failNow("pulse_wait", "no tx_done/tx_error within 10000 cycles");
    endtask

    task automatic deviceFrame();
        logic [10:0] bits;
        dev_active = 1'b1;
        dev_edges  = 0;
        repeat (HALF) @(negedge clk);
        bits[0] = ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            dev_edges   = i;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            bits[i]     = ps2_data_in;
            if (glitch_en && i >= 2 && i <= 9) begin
                repeat (10) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (5) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (HALF - 15) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        if (dev_mode == DEV_NACK) begin
            dev_clk_low = 1'b1;
            dev_edges   = 11;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end else begin
            dev_data_low = 1'b1;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            dev_edges   = 11;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (5) @(negedge clk);
            dev_data_low = 1'b0;
            dev_frames.push_back(bits);
        end
        dev_active = 1'b0;
    endtask

    // Device model: starts clocking once the host has released the clock with the start bit on data.
    initial begin
        forever begin
            @(negedge clk);
            if (dev_mode != DEV_SILENT && !rst && ps2_data_oe && !ps2_clk_oe) deviceFrame();
        end
    end

    // Scoreboard monitor plus phase-length measurements, sampled on the falling clock edge.
    initial begin
        exp_t        e;
        logic [10:0] f;
        logic        prev_clk_oe = 1'b0;
        int          inh_cnt = 0;
        int          st_cnt = 0;
        forever begin
            @(negedge clk);
            if (tx_valid && tx_ready && !rst) accept_count++;
            if (prev_clk_oe && !ps2_clk_oe && ps2_data_oe) begin
                release_cyc = cyc;
                inhibit_len = inh_cnt;
                start_len   = st_cnt;
            end
            if (!ps2_clk_oe) begin
                inh_cnt = 0;
                st_cnt  = 0;
            end else if (!ps2_data_oe) begin
                inh_cnt++;
            end else begin
                st_cnt++;
            end
            prev_clk_oe = ps2_clk_oe;
            if (tx_error) timeout_len = cyc - release_cyc;
            if (tx_done || tx_error) begin
                if (exp_q.size() == 0) begin
                    failNow("unexpected_pulse", $sformatf("done=%0b error=%0b, required no pulse", tx_done, tx_error));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pulse_is_done", 32'(tx_done), 32'(e.is_done));
                    checkOutput("pulse_is_error", 32'(tx_error), 32'(!e.is_done));
                    if (e.check_frame) begin
                        if (dev_frames.size() == 0) begin
                            failNow("device_frame", "no frame captured by device, required one");
                        end else begin
                            f = dev_frames.pop_front();
                            checkOutput("device_frame", 32'(f), 32'(e.frame));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen;
        int   acc0;
        int   n;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_tx_done", 32'(tx_done), 32'd0);
        checkOutput("reset_tx_error", 32'(tx_error), 32'd0);
        checkOutput("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("reset_data_oe", 32'(ps2_data_oe), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] sending 0xED");
        dev_mode = DEV_NORMAL;
        applyStimulus(8'hED, 1'b1, 1'b1);
        waitDone("ed_done");
        checkOutput("inhibit_len", 32'(inhibit_len), 32'(INHIBIT));
        checkOutput("start_len", 32'(start_len), 32'(START));

        $display("[TB] parity vectors");
        applyStimulus(8'h01, 1'b0, 1'b1);
        waitDone("x01_done");
        applyStimulus(8'h00, 1'b1, 1'b1);
        waitDone("x00_done");
        applyStimulus(8'hFF, 1'b1, 1'b1);
        waitDone("xff_done");

        $display("[TB] silent device timeout");
        dev_mode = DEV_SILENT;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        waitPulse(seen);
        if (seen) begin
            checkOutput("timeout_error", 32'(tx_error), 32'd1);
            checkOutput("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
            checkOutput("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
            @(negedge clk);
            checkOutput("timeout_len", 32'(timeout_len), 32'(TIMEOUT));
            checkOutput("timeout_tx_ready", 32'(tx_ready), 32'd1);
        end
        waitDone("timeout_scoreboard");

        $display("[TB] device NACK");
        dev_mode = DEV_NACK;
        applyStimulus(8'h3C, 1'b1, 1'b0);
        waitPulse(seen);
        if (seen) checkOutput("nack_error", 32'(tx_error), 32'd1);
        dev_mode = DEV_NORMAL;
        applyStimulus(8'hFF, 1'b1, 1'b1);
        waitDone("after_nack_done");

        $display("[TB] reset mid-transfer");
        acc0     = accept_count;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        n = 0;
        while (dev_edges != 5 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (dev_edges != 5) failNow("bit5_wait", "device never reached edge 5");
        repeat (10) @(negedge clk);
        rst      = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("rst_mid_data_oe", 32'(ps2_data_oe), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_tx_done", 32'(tx_done), 32'd0);
        checkOutput("rst_mid_tx_error", 32'(tx_error), 32'd0);
        checkOutput("held_valid_accepts", 32'(accept_count - acc0), 32'd1);
        rst = 1'b0;
        n = 0;
        while (dev_active && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (dev_active) failNow("device_idle_wait", "device model still active after 5000 cycles");
        dev_frames.delete();
        repeat (20) @(negedge clk);

`ifdef PS2_TX_FILTER_EN
        $display("[TB] glitch filter");
        glitch_en = 1'b1;
        applyStimulus(8'hED, 1'b1, 1'b1);
        waitDone("glitch_done");
        glitch_en = 1'b0;
`endif

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
